// File: rtl/segment_display.sv
// segment_display: registered hex-to-seven-segment decoder with selectable polarity and hex/blank upper codes
module segment_display #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  output logic [6:0] o_Segment
);
  localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  logic [6:0] w_hi;
  logic [6:0] r_seg;
  // active-high abcdefg lookup; codes 10-15 go blank when hex display is disabled
  always_comb begin
    w_hi = 7'b0000000;
    case (digit)
      4'd0:    w_hi = 7'b1111110;
      4'd1:    w_hi = 7'b0110000;
      4'd2:    w_hi = 7'b1101101;
      4'd3:    w_hi = 7'b1111001;
      4'd4:    w_hi = 7'b0110011;
      4'd5:    w_hi = 7'b1011011;
      4'd6:    w_hi = 7'b1011111;
      4'd7:    w_hi = 7'b1110000;
      4'd8:    w_hi = 7'b1111111;
      4'd9:    w_hi = 7'b1111011;
      4'd10:   w_hi = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'd11:   w_hi = HEX_EN ? 7'b0011111 : 7'b0000000;
      4'd12:   w_hi = HEX_EN ? 7'b1001110 : 7'b0000000;
      4'd13:   w_hi = HEX_EN ? 7'b0111101 : 7'b0000000;
      4'd14:   w_hi = HEX_EN ? 7'b1001111 : 7'b0000000;
      4'd15:   w_hi = HEX_EN ? 7'b1000111 : 7'b0000000;
      default: w_hi = 7'b0000000;
    endcase
  end
  // register the polarity-adjusted pattern; reset blanks the display
  always_ff @(posedge clk) begin
    if (!rst_n) r_seg <= BLANK;
    else        r_seg <= ACTIVE_LOW ? ~w_hi : w_hi;
  end
  assign o_Segment = r_seg;
endmodule

// File: tb/tb_segment_display.sv
// tb_segment_display: directed checks of decode, polarity, hex enable, latency and reset
module tb_segment_display;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [6:0] seg_def, seg_nohex, seg_hi;
  int         errors = 0;
  int         checks = 0;
  logic [6:0] exp_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  segment_display u_def (.clk(clk), .rst_n(rst_n), .digit(digit), .o_Segment(seg_def));
  segment_display #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_nohex (.clk(clk), .rst_n(rst_n), .digit(digit), .o_Segment(seg_nohex));
  segment_display #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_hi (.clk(clk), .rst_n(rst_n), .digit(digit), .o_Segment(seg_hi));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input logic rn, input logic [3:0] d);
    rst_n = rn;
    digit = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    step(1'b0, 4'd5);
    check("rst_def", seg_def, 7'b1111111);
    check("rst_nohex", seg_nohex, 7'b1111111);
    check("rst_hi", seg_hi, 7'b0000000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd5);
      check($sformatf("rst_hold%0d", i), seg_def, 7'b1111111);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'(i));
      check($sformatf("def_%0d", i), seg_def, exp_tab[i]);
      check($sformatf("nohex_%0d", i), seg_nohex, i < 10 ? exp_tab[i] : 7'b1111111);
      check($sformatf("hi_%0d", i), seg_hi, ~exp_tab[i]);
    end
    step(1'b1, 4'd0);
    check("hi_zero", seg_hi, 7'b1111110);
    step(1'b1, 4'd8);
    check("hi_eight", seg_hi, 7'b1111111);
    step(1'b1, 4'd3);
    check("lat_3", seg_def, 7'b0000110);
    digit = 4'd7;
    #3;
    check("lat_hold", seg_def, 7'b0000110);
    @(posedge clk);
    #1;
    check("lat_7", seg_def, 7'b0001111);
    step(1'b1, 4'd1);
    check("mid_1", seg_def, 7'b1001111);
    step(1'b1, 4'd2);
    check("mid_2", seg_def, 7'b0010010);
    step(1'b0, 4'd3);
    check("mid_rst", seg_def, 7'b1111111);
    check("mid_rst_hi", seg_hi, 7'b0000000);
    step(1'b1, 4'd9);
    check("mid_rel9", seg_def, 7'b0000100);
    check("mid_rel9_hi", seg_hi, 7'b1111011);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
